// File: rtl/lane_dly_step_ctrl.sv
// lane_dly_step_ctrl
// -----------------------------------------------------------------------------
// Tap-move sequencer that sits directly in front of one DDR4 PHY lane
// controller, in the FAB_CLK domain. Training logic issues move or reload
// requests. This block turns each request into the lane's
// DELAY_LINE_SEL/LOAD/DIRECTION/MOVE controls and applies the required pause,
// setup and gap timing around every pulse. It tracks the RX and TX tap
// positions and stops a move burst when the lane reports out-of-range.
//
// Configuration macro: LANE_DLY_STEP_AUTO_PAUSE_EN
//   defined   : HS_IO_CLK_PAUSE is wrapped around every burst (PAUSE/UNPAUSE).
//   undefined : no PAUSE/UNPAUSE phases; HS_IO_CLK_PAUSE is tied low.
//
// Ports
//   FAB_CLK, ARST_N                     clock, async active-low reset
//   REQ_VALID/READY                     request handshake (READY only in IDLE)
//   REQ_SEL/DIR/LOAD/STEPS              line (0=RX,1=TX), direction, reload, count
//   RX/TX_DELAY_LINE_OUT_OF_RANGE       lane range status
//   DELAY_LINE_SEL/LOAD/DIRECTION/MOVE  lane delay-line controls
//   HS_IO_CLK_PAUSE                     lane clock pause
//   BUSY, DONE, OOR_ERR                 status (DONE is a one-cycle pulse)
//   RX_TAP, TX_TAP                      tracked tap positions
// All outputs are registered.
// -----------------------------------------------------------------------------
module lane_dly_step_ctrl #(
    parameter int PAUSE_CYCLES   = 4,
    parameter int MOVE_GAP       = 3,
    parameter int UNPAUSE_CYCLES = 2,
    parameter int DEFAULT_TAP    = 1,
    parameter int MAX_TAP        = 255
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_SEL,
    input  logic       REQ_DIR,
    input  logic       REQ_LOAD,
    input  logic [7:0] REQ_STEPS,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    output logic       BUSY,
    output logic       DONE,
    output logic       OOR_ERR,
    output logic [7:0] RX_TAP,
    output logic [7:0] TX_TAP
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAUSE   = 3'd1,
        ST_SETUP   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_GAP     = 3'd4,
        ST_UNPAUSE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Phase counters count up from 0 and stop at the phase's last cycle.
    localparam logic [3:0] PAUSE_LAST   = 4'(PAUSE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST     = 4'(MOVE_GAP - 1);
    localparam logic [3:0] UNPAUSE_LAST = 4'(UNPAUSE_CYCLES - 1);
    localparam logic [7:0] DEF_TAP8     = 8'(DEFAULT_TAP);
    localparam logic [7:0] MAX_TAP8     = 8'(MAX_TAP);

`ifdef LANE_DLY_STEP_AUTO_PAUSE_EN
    localparam state_t ST_AFTER_ACCEPT = ST_PAUSE;
    localparam state_t ST_AFTER_BURST  = ST_UNPAUSE;
`else
    localparam state_t ST_AFTER_ACCEPT = ST_SETUP;
    localparam state_t ST_AFTER_BURST  = ST_DONE;
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] steps_q, steps_d;
    logic       sel_q, sel_d, dir_q, dir_d, load_q, load_d;
    logic       oor_q, oor_d;
    logic [7:0] rx_tap_q, rx_tap_d, tx_tap_q, tx_tap_d;
    logic       oor_in_s;

    logic       ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic       pause_q, pause_d, move_q, move_d, dl_load_q, dl_load_d;
    logic       dl_sel_q, dl_sel_d, dl_dir_q, dl_dir_d;

    // One saturating tap step; saturation never suppresses the lane pulse.
    function automatic logic [7:0] tap_step(input logic [7:0] tap, input logic up);
        logic [7:0] res;
        if (up) begin
            res = (tap == MAX_TAP8) ? tap : tap + 8'd1;
        end else begin
            res = (tap == 8'd0) ? tap : tap - 8'd1;
        end
        return res;
    endfunction

    // State, counters, latched request and tracked taps.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            steps_q  <= 8'd0;
            sel_q    <= 1'b0;
            dir_q    <= 1'b0;
            load_q   <= 1'b0;
            oor_q    <= 1'b0;
            rx_tap_q <= DEF_TAP8;
            tx_tap_q <= DEF_TAP8;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            load_q   <= load_d;
            oor_q    <= oor_d;
            rx_tap_q <= rx_tap_d;
            tx_tap_q <= tx_tap_d;
        end
    end

    // Next-state logic: sequencing, abort on out-of-range, and tap update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = 4'd0;
        steps_d  = steps_q;
        sel_d    = sel_q;
        dir_d    = dir_q;
        load_d   = load_q;
        oor_d    = oor_q;
        rx_tap_d = rx_tap_q;
        tx_tap_d = tx_tap_q;
        oor_in_s = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    steps_d = REQ_STEPS;
                    load_d  = REQ_LOAD;
                    oor_d   = 1'b0;
                    if ((REQ_STEPS == 8'd0) && !REQ_LOAD) begin
                        // Empty request: keep SEL/DIR low so the lane sees no activity.
                        sel_d   = 1'b0;
                        dir_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        sel_d   = REQ_SEL;
                        dir_d   = REQ_DIR;
                        state_d = ST_AFTER_ACCEPT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (cnt_q == PAUSE_LAST) begin
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    // Only sample point of the lane's range status.
                    if (oor_in_s) begin
                        oor_d   = 1'b1;
                        steps_d = 8'd0;
                        state_d = ST_AFTER_BURST;
                    end else if (load_q) begin
                        if (sel_q) begin
                            tx_tap_d = DEF_TAP8;
                        end else begin
                            rx_tap_d = DEF_TAP8;
                        end
                        state_d = ST_AFTER_BURST;
                    end else begin
                        if (sel_q) begin
                            tx_tap_d = tap_step(tx_tap_q, dir_q);
                        end else begin
                            rx_tap_d = tap_step(rx_tap_q, dir_q);
                        end
                        steps_d = steps_q - 8'd1;
                        state_d = (steps_q == 8'd1) ? ST_AFTER_BURST : ST_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_UNPAUSE: begin
                if (cnt_q == UNPAUSE_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output comes from a flop.
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        move_d    = (state_d == ST_PULSE) && !load_d;
        dl_load_d = (state_d == ST_PULSE) && load_d;
        dl_sel_d  = (state_d != ST_IDLE) ? sel_d : 1'b0;
        dl_dir_d  = (state_d != ST_IDLE) ? dir_d : 1'b0;
`ifdef LANE_DLY_STEP_AUTO_PAUSE_EN
        pause_d   = state_d inside {ST_PAUSE, ST_SETUP, ST_PULSE, ST_GAP, ST_UNPAUSE};
`else
        pause_d   = 1'b0;
`endif
    end

    // Output registers.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pause_q   <= 1'b0;
            move_q    <= 1'b0;
            dl_load_q <= 1'b0;
            dl_sel_q  <= 1'b0;
            dl_dir_q  <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pause_q   <= pause_d;
            move_q    <= move_d;
            dl_load_q <= dl_load_d;
            dl_sel_q  <= dl_sel_d;
            dl_dir_q  <= dl_dir_d;
        end
    end

    assign REQ_READY            = ready_q;
    assign BUSY                 = busy_q;
    assign DONE                 = done_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_LOAD      = dl_load_q;
    assign DELAY_LINE_SEL       = dl_sel_q;
    assign DELAY_LINE_DIRECTION = dl_dir_q;
    assign OOR_ERR              = oor_q;
    assign RX_TAP               = rx_tap_q;
    assign TX_TAP               = tx_tap_q;

endmodule

// File: tb/tb_lane_dly_step_ctrl.sv
// Self-checking bench for lane_dly_step_ctrl: directed and randomized requests
// compared against a request-level reference model (pulse count, latency,
// final tap positions, error flag).
module tb_lane_dly_step_ctrl;

    localparam int P    = 4;
    localparam int G    = 3;
    localparam int U    = 2;
    localparam int DEF  = 1;
    localparam int MAXT = 255;
`ifdef LANE_DLY_STEP_AUTO_PAUSE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_valid, req_ready, req_sel, req_dir, req_load;
    logic [7:0] req_steps;
    logic       rx_oor, tx_oor;
    logic       dl_sel, dl_load, dl_dir, dl_move, pause, busy, done, oor_err;
    logic [7:0] rx_tap, tx_tap;

    int n_tests = 0;
    int n_fail  = 0;
    int model_tap[2];

    lane_dly_step_ctrl dut (
        .FAB_CLK                    (clk),
        .ARST_N                     (rst_n),
        .REQ_VALID                  (req_valid),
        .REQ_READY                  (req_ready),
        .REQ_SEL                    (req_sel),
        .REQ_DIR                    (req_dir),
        .REQ_LOAD                   (req_load),
        .REQ_STEPS                  (req_steps),
        .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
        .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor),
        .DELAY_LINE_SEL             (dl_sel),
        .DELAY_LINE_LOAD            (dl_load),
        .DELAY_LINE_DIRECTION       (dl_dir),
        .DELAY_LINE_MOVE            (dl_move),
        .HS_IO_CLK_PAUSE            (pause),
        .BUSY                       (busy),
        .DONE                       (done),
        .OOR_ERR                    (oor_err),
        .RX_TAP                     (rx_tap),
        .TX_TAP                     (tx_tap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Idle/reset view of all outputs against the model taps.
    task automatic check_idle(input string tag);
        check_val({tag, "_ready"}, req_ready, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_move"}, dl_move, 0);
        check_val({tag, "_load"}, dl_load, 0);
        check_val({tag, "_sel"}, dl_sel, 0);
        check_val({tag, "_dir"}, dl_dir, 0);
        check_val({tag, "_pause"}, pause, 0);
        check_val({tag, "_rxtap"}, rx_tap, model_tap[0]);
        check_val({tag, "_txtap"}, tx_tap, model_tap[1]);
    endtask

    // Issue one request; k = pulse number at which the selected line reports
    // out-of-range (0 = never). Busy-time REQ_VALID noise is injected.
    task automatic run_req(input bit sel, input bit dir, input bit ld, input int steps, input int k);
        int  exp_pulses, exp_lat, c, pulses, last_p, applied, t;
        int  pos_err, flag_err, stab_err, pause_err, busy_err;
        logic oor_at0;
        bit  zero, abort_on, done_seen;
        zero       = (steps == 0) && !ld;
        exp_pulses = zero ? 0 : (ld ? 1 : steps);
        if (k > exp_pulses) k = 0;
        if (k != 0) exp_pulses = k;
        exp_lat = zero ? 0 : 1 + exp_pulses * (1 + G) + (AUTO ? P + U : 0);

        @(negedge clk);
        check_val("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_load  = ld;
        req_steps = steps[7:0];
        @(posedge clk);
        c = 0; pulses = 0; last_p = -100; abort_on = 0; done_seen = 0; oor_at0 = 1'b0;
        pos_err = 0; flag_err = 0; stab_err = 0; pause_err = 0; busy_err = 0;
        while (!done_seen && c <= exp_lat + 16) begin
            @(negedge clk);
            if (c == 0) oor_at0 = oor_err;
            if (dl_move || dl_load) begin
                if (c != (AUTO ? P : 0) + 1 + pulses * (1 + G)) pos_err++;
                if (dl_move !== !ld || dl_load !== ld) flag_err++;
                pulses++;
                last_p = c;
                if (pulses == k) abort_on = 1;
            end
            if (zero && (dl_sel || dl_dir || dl_move || dl_load)) flag_err++;
            if (!zero && (dl_sel !== sel || (!ld && dl_dir !== dir))) stab_err++;
            if (pause !== (AUTO && !zero && (c < exp_lat))) pause_err++;
            if (req_ready !== 1'b0 || busy !== 1'b1) busy_err++;
            if (done) done_seen = 1;
            // Inputs for the edge that ends cycle c.
            if (done_seen) begin
                req_valid = 1'b0;
            end else begin
                req_valid = 1'($urandom_range(0, 1));
                req_sel   = 1'($urandom_range(0, 1));
                req_dir   = 1'($urandom_range(0, 1));
                req_load  = 1'($urandom_range(0, 1));
                req_steps = 8'($urandom_range(0, 255));
            end
            begin
                logic sel_line;
                if (abort_on) sel_line = 1'b1;
                else if (c == last_p + G) sel_line = 1'b0;
                else sel_line = 1'($urandom_range(0, 1));
                if (sel) begin
                    tx_oor = sel_line;
                    rx_oor = 1'($urandom_range(0, 1));
                end else begin
                    rx_oor = sel_line;
                    tx_oor = 1'($urandom_range(0, 1));
                end
            end
            if (!done_seen) c++;
        end
        check_val("done_seen", done_seen, 1);
        check_val("latency", c, exp_lat);
        check_val("pulse_count", pulses, exp_pulses);
        check_val("pulse_spacing_errs", pos_err, 0);
        check_val("pulse_kind_errs", flag_err, 0);
        check_val("sel_dir_errs", stab_err, 0);
        check_val("pause_errs", pause_err, 0);
        check_val("busy_ready_errs", busy_err, 0);
        check_val("oor_cleared_on_accept", oor_at0, 0);

        if (!zero) begin
            if (ld) begin
                if (k == 0) model_tap[sel] = DEF;
            end else begin
                applied = (k != 0) ? k - 1 : steps;
                t = dir ? model_tap[sel] + applied : model_tap[sel] - applied;
                if (t > MAXT) t = MAXT;
                if (t < 0) t = 0;
                model_tap[sel] = t;
            end
        end
        @(negedge clk);
        check_idle("after_done");
        check_val("oor_err", oor_err, (k != 0) ? 1 : 0);
    endtask

    // Reset asserted during a GAP cycle of a burst.
    task automatic reset_mid_burst();
        int n;
        @(negedge clk);
        rx_oor = 1'b0; tx_oor = 1'b0;
        req_valid = 1'b1; req_sel = 1'b0; req_dir = 1'b1; req_load = 1'b0; req_steps = 8'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!dl_move && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_val("rst_burst_move_seen", dl_move, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_tap[0] = DEF;
        model_tap[1] = DEF;
        check_idle("rst_mid");
        check_val("rst_mid_oor", oor_err, 0);
        @(negedge clk);
        check_idle("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_sel = 1'b0; req_dir = 1'b0; req_load = 1'b0; req_steps = 8'd0;
        rx_oor = 1'b0; tx_oor = 1'b0;
        model_tap[0] = DEF;
        model_tap[1] = DEF;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check_val("reset_oor", oor_err, 0);
        rst_n = 1'b1;

        run_req(1'b0, 1'b1, 1'b0, 3, 0);    // RX 1 -> 4
        run_req(1'b1, 1'b1, 1'b0, 9, 0);    // TX 1 -> 10
        run_req(1'b1, 1'b0, 1'b1, 0, 0);    // TX reload -> 1
        run_req(1'b1, 1'b1, 1'b0, 5, 2);    // abort on 2nd sample: TX 1 -> 2
        run_req(1'b0, 1'b0, 1'b0, 0, 0);    // zero steps, clears OOR_ERR
        run_req(1'b0, 1'b0, 1'b1, 7, 0);    // RX reload -> 1
        run_req(1'b0, 1'b0, 1'b0, 3, 0);    // RX 1 -> 0 saturated
        run_req(1'b1, 1'b1, 1'b0, 255, 0);  // TX saturates at 255
        run_req(1'b1, 1'b1, 1'b0, 2, 0);    // pulses still issued at MAX
        run_req(1'b1, 1'b0, 1'b1, 0, 1);    // reload aborted: TX unchanged

        for (int i = 0; i < 60; i++) begin
            bit r_sel, r_dir, r_ld;
            int r_steps, r_k;
            r_sel   = 1'($urandom_range(0, 1));
            r_dir   = 1'($urandom_range(0, 1));
            r_ld    = ($urandom_range(0, 7) == 0);
            r_steps = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            r_k     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_req(r_sel, r_dir, r_ld, r_steps, r_k);
        end

        reset_mid_burst();
        run_req(1'b1, 1'b0, 1'b0, 2, 0);    // TX 1 -> 0 after reset

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
